// File: rtl/writeback_if.sv
// Bundle between execute, data memory and the register file write port as seen by the writeback stage.
// The stage uses the slave side; the surrounding core (or a bench) uses the master side.
interface writeback_if #(
   parameter int XLEN = 32
) ();
   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_rd;
   logic [1:0]      wb_src;
   logic [XLEN-1:0] wb_alu_result;
   logic [XLEN-1:0] wb_pc_plus4;
   logic [1:0]      wb_ld_size;
   logic            wb_ld_unsigned;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            rf_we;
   logic [4:0]      rf_rd;
   logic [XLEN-1:0] rf_wdata;
   logic            busy;
   logic            load_timeout;

   modport slave (
      input  wb_valid, wb_rd, wb_src, wb_alu_result, wb_pc_plus4,
      input  wb_ld_size, wb_ld_unsigned, mem_rvalid, mem_rdata,
      output wb_ready, rf_we, rf_rd, rf_wdata, busy, load_timeout
   );

   modport master (
      output wb_valid, wb_rd, wb_src, wb_alu_result, wb_pc_plus4,
      output wb_ld_size, wb_ld_unsigned, mem_rvalid, mem_rdata,
      input  wb_ready, rf_we, rf_rd, rf_wdata, busy, load_timeout
   );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: picks ALU / PC+4 / load data, waits for and aligns load responses,
// and issues a single-cycle registered register-file write.
module writeback_stage #(
   parameter int XLEN         = 32,
   parameter int LOAD_TIMEOUT = 255,
   parameter int X0_WRITE_EN  = 0
) (
   input  logic        clk,
   input  logic        reset,
   writeback_if.slave  bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_MEM = 2'd1;
   localparam logic [1:0] ST_WRITE    = 2'd2;

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;

   localparam int              CNT_W       = $clog2(LOAD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LOAD_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [1:0]       state_reg, state_next;
   logic [4:0]       rd_reg, rd_next;
   logic [1:0]       size_reg, size_next;
   logic             unsigned_reg, unsigned_next;
   logic [1:0]       offset_reg, offset_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [CNT_W-1:0] count_inc;
   logic             rf_we_reg, rf_we_next;
   logic [4:0]       rf_rd_reg, rf_rd_next;
   logic [XLEN-1:0]  rf_wdata_reg, rf_wdata_next;
   logic             timeout_reg, timeout_next;

   logic             transfer;
   logic [XLEN-1:0]  load_data;

   logic [7:0]       byte_lane [4];
   logic [15:0]      half_lane [2];
   logic [7:0]       sel_byte;
   logic [15:0]      sel_half;
   logic             fill_bit;

   function automatic logic write_allowed(input logic [4:0] rd);
      return (rd != 5'd0) || (X0_WRITE_EN != 0);
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_lane
         assign byte_lane[gi] = bus.mem_rdata[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half_lane
         assign half_lane[gi] = bus.mem_rdata[16*gi +: 16];
      end
   endgenerate

   // Lane select uses the address offset captured at transfer, not the live bus.
   always_comb begin
      sel_byte  = byte_lane[offset_reg];
      sel_half  = half_lane[offset_reg[1]];
      fill_bit  = 1'b0;
      load_data = bus.mem_rdata;
      case (size_reg)
         SIZE_BYTE: begin
            fill_bit  = !unsigned_reg && sel_byte[7];
            load_data = {{(XLEN-8){fill_bit}}, sel_byte};
         end
         SIZE_HALF: begin
            fill_bit  = !unsigned_reg && sel_half[15];
            load_data = {{(XLEN-16){fill_bit}}, sel_half};
         end
         default: load_data = bus.mem_rdata;
      endcase
   end

   assign transfer  = bus.wb_valid && bus.wb_ready;
   assign count_inc = count_reg + CNT_ONE;

   always_comb begin
      state_next    = state_reg;
      rd_next       = rd_reg;
      size_next     = size_reg;
      unsigned_next = unsigned_reg;
      offset_next   = offset_reg;
      count_next    = count_reg;
      rf_we_next    = 1'b0;
      rf_rd_next    = rf_rd_reg;
      rf_wdata_next = rf_wdata_reg;
      timeout_next  = timeout_reg;

      case (state_reg)
         ST_IDLE: begin
            if (transfer) begin
               rd_next       = bus.wb_rd;
               size_next     = bus.wb_ld_size;
               unsigned_next = bus.wb_ld_unsigned;
               offset_next   = bus.wb_alu_result[1:0];
               case (bus.wb_src)
                  SRC_ALU, SRC_PC4: begin
                     state_next = ST_WRITE;
                     if (write_allowed(bus.wb_rd)) begin
                        rf_we_next    = 1'b1;
                        rf_rd_next    = bus.wb_rd;
                        rf_wdata_next = (bus.wb_src == SRC_ALU) ? bus.wb_alu_result
                                                                : bus.wb_pc_plus4;
                     end
                  end
                  SRC_LOAD: begin
                     state_next = ST_WAIT_MEM;
                     count_next = '0;
                  end
                  default: state_next = ST_IDLE;
               endcase
            end
         end

         ST_WAIT_MEM: begin
            // A response on the expiry edge still wins over the abort.
            if (bus.mem_rvalid) begin
               state_next = ST_WRITE;
               if (write_allowed(rd_reg)) begin
                  rf_we_next    = 1'b1;
                  rf_rd_next    = rd_reg;
                  rf_wdata_next = load_data;
               end
            end else begin
               count_next = count_inc;
               if (count_inc == TIMEOUT_CNT) begin
                  timeout_next = 1'b1;
                  state_next   = ST_IDLE;
               end
            end
         end

         ST_WRITE: state_next = ST_IDLE;

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         rd_reg       <= '0;
         size_reg     <= '0;
         unsigned_reg <= 1'b0;
         offset_reg   <= '0;
         count_reg    <= '0;
         rf_we_reg    <= 1'b0;
         rf_rd_reg    <= '0;
         rf_wdata_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rd_reg       <= rd_next;
         size_reg     <= size_next;
         unsigned_reg <= unsigned_next;
         offset_reg   <= offset_next;
         count_reg    <= count_next;
         rf_we_reg    <= rf_we_next;
         rf_rd_reg    <= rf_rd_next;
         rf_wdata_reg <= rf_wdata_next;
         timeout_reg  <= timeout_next;
      end
   end

   assign bus.wb_ready     = (state_reg == ST_IDLE) && !reset;
   assign bus.busy         = (state_reg != ST_IDLE);
   assign bus.rf_we        = rf_we_reg;
   assign bus.rf_rd        = rf_rd_reg;
   assign bus.rf_wdata     = rf_wdata_reg;
   assign bus.load_timeout = timeout_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: two instances (x0 writes off / on) run in lockstep on one stimulus.
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_src;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_pc_plus4;
   logic [1:0]  wb_ld_size;
   logic        wb_ld_unsigned;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   writeback_if #(.XLEN(32)) bus0 ();
   writeback_if #(.XLEN(32)) bus1 ();

   assign bus0.wb_valid = wb_valid;        assign bus1.wb_valid = wb_valid;
   assign bus0.wb_rd = wb_rd;              assign bus1.wb_rd = wb_rd;
   assign bus0.wb_src = wb_src;            assign bus1.wb_src = wb_src;
   assign bus0.wb_alu_result = wb_alu_result; assign bus1.wb_alu_result = wb_alu_result;
   assign bus0.wb_pc_plus4 = wb_pc_plus4;  assign bus1.wb_pc_plus4 = wb_pc_plus4;
   assign bus0.wb_ld_size = wb_ld_size;    assign bus1.wb_ld_size = wb_ld_size;
   assign bus0.wb_ld_unsigned = wb_ld_unsigned; assign bus1.wb_ld_unsigned = wb_ld_unsigned;
   assign bus0.mem_rvalid = mem_rvalid;    assign bus1.mem_rvalid = mem_rvalid;
   assign bus0.mem_rdata = mem_rdata;      assign bus1.mem_rdata = mem_rdata;

   writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(4), .X0_WRITE_EN(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave));
   writeback_stage #(.XLEN(32), .LOAD_TIMEOUT(4), .X0_WRITE_EN(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents one result for exactly one cycle; returns at the negedge after the transfer edge.
   task automatic send(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [1:0] size, input logic uns);
      @(negedge clk);
      wb_rd = rd; wb_src = src; wb_alu_result = alu; wb_pc_plus4 = pc;
      wb_ld_size = size; wb_ld_unsigned = uns; wb_valid = 1'b1;
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data);
      mem_rvalid = 1'b1; mem_rdata = data;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus0.wb_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus0.wb_ready); end
      checks++; if (bus0.rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus0.rf_we); end
      checks++; if (bus0.rf_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d exp 0", bus0.rf_rd); end
      checks++; if (bus0.rf_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus0.rf_wdata); end
      checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus0.busy); end
      checks++; if (bus0.load_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", bus0.load_timeout); end
      reset = 1'b0;
      #1;
      checks++; if (bus0.wb_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", bus0.wb_ready); end
      $display("test_reset done");
   endtask

   task automatic test_alu;
      send(5'd5, 2'b00, 32'h1234_5678, 32'h0000_0400, 2'b10, 1'b0);
      checks++; if (bus0.rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got %b exp 1", bus0.rf_we); end
      checks++; if (bus0.rf_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", bus0.rf_rd); end
      checks++; if (bus0.rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL alu_wdata got %h exp 12345678", bus0.rf_wdata); end
      checks++; if (bus0.wb_ready !== 1'b0) begin errors++; $display("FAIL alu_ready_low got %b exp 0", bus0.wb_ready); end
      @(negedge clk);
      checks++; if (bus0.rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_pulse got %b exp 0", bus0.rf_we); end
      checks++; if (bus0.wb_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_back got %b exp 1", bus0.wb_ready); end
      checks++; if (bus0.rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL alu_hold got %h exp 12345678", bus0.rf_wdata); end
      $display("test_alu rd=5 wdata=%h", bus0.rf_wdata);
   endtask

   task automatic test_pc4;
      send(5'd1, 2'b10, 32'h0000_DEAD, 32'h0000_0104, 2'b00, 1'b0);
      checks++; if (bus0.rf_we !== 1'b1) begin errors++; $display("FAIL pc4_we got %b exp 1", bus0.rf_we); end
      checks++; if (bus0.rf_wdata !== 32'h0000_0104) begin errors++; $display("FAIL pc4_wdata got %h exp 00000104", bus0.rf_wdata); end
      $display("test_pc4 wdata=%h", bus0.rf_wdata);
   endtask

   task automatic test_load_byte;
      send(5'd7, 2'b01, 32'h1000_0002, 32'h0, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus0.rf_we !== 1'b0 || bus0.busy !== 1'b1) begin errors++; $display("FAIL lb_wait%0d we=%b busy=%b exp we=0 busy=1", i, bus0.rf_we, bus0.busy); end
         @(negedge clk);
      end
      respond(32'h0080_0000);
      checks++; if (bus0.rf_we !== 1'b1) begin errors++; $display("FAIL lb_we got %b exp 1", bus0.rf_we); end
      checks++; if (bus0.rf_rd !== 5'd7) begin errors++; $display("FAIL lb_rd got %0d exp 7", bus0.rf_rd); end
      checks++; if (bus0.rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", bus0.rf_wdata); end
      checks++; if (bus0.load_timeout !== 1'b0) begin errors++; $display("FAIL lb_no_timeout got %b exp 0", bus0.load_timeout); end
      $display("test_load_byte signed wdata=%h", bus0.rf_wdata);

      send(5'd8, 2'b01, 32'h1000_0002, 32'h0, 2'b00, 1'b1);
      repeat (3) @(negedge clk);
      respond(32'h0080_0000);
      checks++; if (bus0.rf_we !== 1'b1 || bus0.rf_wdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu we=%b wdata=%h exp we=1 wdata=00000080", bus0.rf_we, bus0.rf_wdata); end
      $display("test_load_byte unsigned wdata=%h", bus0.rf_wdata);
   endtask

   task automatic test_load_half_word;
      // Minimum latency: response on the first WAIT_MEM edge.
      send(5'd9, 2'b01, 32'h2000_0002, 32'h0, 2'b01, 1'b0);
      checks++; if (bus0.rf_we !== 1'b0) begin errors++; $display("FAIL lh_early_we got %b exp 0", bus0.rf_we); end
      respond(32'h8001_1234);
      checks++; if (bus0.rf_we !== 1'b1 || bus0.rf_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_off2 we=%b wdata=%h exp we=1 wdata=ffff8001", bus0.rf_we, bus0.rf_wdata); end
      $display("test_load_half off2 wdata=%h", bus0.rf_wdata);

      send(5'd9, 2'b01, 32'h2000_0003, 32'h0, 2'b01, 1'b0);
      @(negedge clk);
      respond(32'h8001_1234);
      checks++; if (bus0.rf_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_off3 got %h exp ffff8001", bus0.rf_wdata); end
      $display("test_load_half off3 wdata=%h", bus0.rf_wdata);

      send(5'd10, 2'b01, 32'h2000_0000, 32'h0, 2'b01, 1'b1);
      respond(32'h8001_9234);
      checks++; if (bus0.rf_wdata !== 32'h0000_9234) begin errors++; $display("FAIL lhu_off0 got %h exp 00009234", bus0.rf_wdata); end
      $display("test_load_half unsigned off0 wdata=%h", bus0.rf_wdata);

      send(5'd11, 2'b01, 32'h2000_0001, 32'h0, 2'b10, 1'b0);
      respond(32'h8001_1234);
      checks++; if (bus0.rf_wdata !== 32'h8001_1234) begin errors++; $display("FAIL lw_off1 got %h exp 80011234", bus0.rf_wdata); end
      $display("test_load_word off1 wdata=%h", bus0.rf_wdata);

      send(5'd12, 2'b01, 32'h2000_0001, 32'h0, 2'b00, 1'b0);
      respond(32'h8001_1234);
      checks++; if (bus0.rf_wdata !== 32'h0000_0012) begin errors++; $display("FAIL lb_off1 got %h exp 00000012", bus0.rf_wdata); end
      $display("test_load_byte off1 wdata=%h", bus0.rf_wdata);

      send(5'd13, 2'b01, 32'h2000_0003, 32'h0, 2'b00, 1'b0);
      respond(32'h8001_1234);
      checks++; if (bus0.rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_off3 got %h exp ffffff80", bus0.rf_wdata); end
      $display("test_load_byte off3 wdata=%h", bus0.rf_wdata);
   endtask

   task automatic test_timeout;
      send(5'd14, 2'b01, 32'h3000_0000, 32'h0, 2'b10, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++; if (bus0.load_timeout !== 1'b0 || bus0.busy !== 1'b1 || bus0.rf_we !== 1'b0) begin errors++; $display("FAIL to_edge%0d timeout=%b busy=%b we=%b exp 0 1 0", i, bus0.load_timeout, bus0.busy, bus0.rf_we); end
      end
      @(negedge clk);
      checks++; if (bus0.load_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", bus0.load_timeout); end
      checks++; if (bus0.busy !== 1'b0 || bus0.rf_we !== 1'b0) begin errors++; $display("FAIL to_abort busy=%b we=%b exp 0 0", bus0.busy, bus0.rf_we); end
      send(5'd15, 2'b00, 32'hCAFE_0001, 32'h0, 2'b00, 1'b0);
      checks++; if (bus0.rf_we !== 1'b1 || bus0.rf_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL to_next_alu we=%b wdata=%h exp 1 cafe0001", bus0.rf_we, bus0.rf_wdata); end
      checks++; if (bus0.load_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", bus0.load_timeout); end
      $display("test_timeout load_timeout=%b", bus0.load_timeout);
   endtask

   task automatic test_reset_mid_load;
      send(5'd16, 2'b01, 32'h4000_0000, 32'h0, 2'b10, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (bus0.wb_ready !== 1'b0) begin errors++; $display("FAIL rml_ready got %b exp 0", bus0.wb_ready); end
      @(negedge clk);
      checks++; if (bus0.rf_we !== 1'b0 || bus0.rf_rd !== 5'd0 || bus0.rf_wdata !== 32'h0) begin errors++; $display("FAIL rml_outputs we=%b rd=%0d wdata=%h exp 0 0 0", bus0.rf_we, bus0.rf_rd, bus0.rf_wdata); end
      checks++; if (bus0.busy !== 1'b0 || bus0.load_timeout !== 1'b0) begin errors++; $display("FAIL rml_state busy=%b timeout=%b exp 0 0", bus0.busy, bus0.load_timeout); end
      reset = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (bus0.rf_we !== 1'b0 || bus0.rf_wdata !== 32'h0) begin errors++; $display("FAIL rml_stale%0d we=%b wdata=%h exp 0 0", i, bus0.rf_we, bus0.rf_wdata); end
      end
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      $display("test_reset_mid_load done");
   endtask

   task automatic test_timeout_boundary;
      send(5'd17, 2'b01, 32'h5000_0000, 32'h0, 2'b10, 1'b0);
      repeat (3) @(negedge clk);
      respond(32'h0BAD_F00D);
      checks++; if (bus0.rf_we !== 1'b1 || bus0.rf_wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL tob_write we=%b wdata=%h exp 1 0badf00d", bus0.rf_we, bus0.rf_wdata); end
      checks++; if (bus0.load_timeout !== 1'b0) begin errors++; $display("FAIL tob_flag got %b exp 0", bus0.load_timeout); end
      $display("test_timeout_boundary wdata=%h", bus0.rf_wdata);
   endtask

   task automatic test_x0_src11;
      send(5'd0, 2'b00, 32'hAAAA_5555, 32'h0, 2'b00, 1'b0);
      checks++; if (bus0.rf_we !== 1'b0 || bus0.busy !== 1'b1) begin errors++; $display("FAIL x0_off we=%b busy=%b exp 0 1", bus0.rf_we, bus0.busy); end
      checks++; if (bus1.rf_we !== 1'b1 || bus1.rf_rd !== 5'd0 || bus1.rf_wdata !== 32'hAAAA_5555) begin errors++; $display("FAIL x0_on we=%b rd=%0d wdata=%h exp 1 0 aaaa5555", bus1.rf_we, bus1.rf_rd, bus1.rf_wdata); end
      @(negedge clk);
      checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL x0_back_idle got %b exp 0", bus0.busy); end
      send(5'd3, 2'b11, 32'h1111_1111, 32'h2222_2222, 2'b00, 1'b0);
      checks++; if (bus0.wb_ready !== 1'b1 || bus0.busy !== 1'b0) begin errors++; $display("FAIL src11_ready ready=%b busy=%b exp 1 0", bus0.wb_ready, bus0.busy); end
      checks++; if (bus0.rf_we !== 1'b0 || bus1.rf_we !== 1'b0) begin errors++; $display("FAIL src11_we we0=%b we1=%b exp 0 0", bus0.rf_we, bus1.rf_we); end
      $display("test_x0_src11 done");
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      wb_rd = 5'd20; wb_src = 2'b00; wb_alu_result = 32'h0000_00A1; wb_valid = 1'b1;
      @(negedge clk);
      checks++; if (bus0.rf_we !== 1'b1 || bus0.rf_wdata !== 32'h0000_00A1) begin errors++; $display("FAIL b2b_first we=%b wdata=%h exp 1 000000a1", bus0.rf_we, bus0.rf_wdata); end
      wb_rd = 5'd21; wb_alu_result = 32'h0000_00B2;
      @(negedge clk);
      checks++; if (bus0.rf_we !== 1'b0 || bus0.wb_ready !== 1'b1 || bus0.rf_wdata !== 32'h0000_00A1) begin errors++; $display("FAIL b2b_gap we=%b ready=%b wdata=%h exp 0 1 000000a1", bus0.rf_we, bus0.wb_ready, bus0.rf_wdata); end
      @(negedge clk);
      wb_valid = 1'b0;
      checks++; if (bus0.rf_we !== 1'b1 || bus0.rf_rd !== 5'd21 || bus0.rf_wdata !== 32'h0000_00B2) begin errors++; $display("FAIL b2b_second we=%b rd=%0d wdata=%h exp 1 21 000000b2", bus0.rf_we, bus0.rf_rd, bus0.rf_wdata); end
      @(negedge clk);
      checks++; if (bus0.rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", bus0.rf_we); end
      $display("test_back_to_back done");
   endtask

   initial begin
      reset = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; wb_src = 2'b11;
      wb_alu_result = 32'h0; wb_pc_plus4 = 32'h0; wb_ld_size = 2'b00; wb_ld_unsigned = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      test_reset;
      test_alu;
      test_pc4;
      test_load_byte;
      test_load_half_word;
      test_timeout;
      test_reset_mid_load;
      test_timeout_boundary;
      test_x0_src11;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
